// File: rtl/mips_state_dumper_if.sv
// mips_state_dumper_if: register-file/data-memory read ports and the outgoing byte stream
interface mips_state_dumper_if #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_ADDR_WIDTH = 5
);
  logic [4:0]                reg_addr;
  logic [DATA_WIDTH-1:0]     reg_data;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_data;
  logic [7:0]                tx_data;
  logic                      tx_valid;
  logic                      tx_ready;
  modport master (
    output reg_addr, mem_addr, tx_data, tx_valid,
    input  reg_data, mem_data, tx_ready
  );
  modport slave (
    input  reg_addr, mem_addr, tx_data, tx_valid,
    output reg_data, mem_data, tx_ready
  );
endinterface

// File: rtl/mips_state_dumper.sv
// mips_state_dumper: serialises PC, register file and a data-memory window into a framed,
// XOR-checksummed byte stream after a halt edge or a start request
module mips_state_dumper #(
  parameter int DATA_WIDTH     = 32,
  parameter int MEM_WORDS      = 32,
  parameter int MEM_ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  halt_i,
  input  logic                  start_i,
  input  logic [DATA_WIDTH-1:0] pc_i,
  mips_state_dumper_if.master   bus,
  output logic                  busy_o,
  output logic                  done_o
);
  typedef enum logic [3:0] {
    IDLE, HDR, PC_B, REG_FETCH, REG_B, MEM_FETCH, MEM_B, CSUM, DONE
  } state_t;

  state_t                    state_q, state_d;
  logic                      halt_q;
  logic [DATA_WIDTH-1:0]     word_q, word_d;
  logic [1:0]                byte_q, byte_d;
  logic [5:0]                idx_q, idx_d;
  logic [7:0]                csum_q, csum_d;
  logic [4:0]                reg_addr_q, reg_addr_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                      trig, word_st, acc, last_reg, last_mem;
  logic [7:0]                tx_byte;

  assign trig     = start_i | (halt_i & ~halt_q);
  assign word_st  = (state_q == PC_B) | (state_q == REG_B) | (state_q == MEM_B);
  assign tx_byte  = (state_q == HDR) ? 8'hA5 :
                    (state_q == CSUM) ? csum_q :
                    word_st ? word_q[DATA_WIDTH-1 -: 8] : 8'h00;
  assign acc      = bus.tx_valid & bus.tx_ready;
  assign last_reg = idx_q == 6'd31;
  assign last_mem = idx_q == 6'(MEM_WORDS - 1);

  assign bus.tx_valid = word_st | (state_q == HDR) | (state_q == CSUM);
  assign bus.tx_data  = tx_byte;
  assign bus.reg_addr = reg_addr_q;
  assign bus.mem_addr = mem_addr_q;
  assign busy_o       = (state_q != IDLE) & (state_q != DONE);
  assign done_o       = state_q == DONE;

  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    byte_d  = byte_q;
    idx_d   = idx_q;
    csum_d  = csum_q;
    case (state_q)
      IDLE: if (trig) begin
        state_d = HDR;
        word_d  = pc_i;
        byte_d  = '0;
        idx_d   = '0;
        csum_d  = '0;
      end
      HDR: state_d = acc ? PC_B : HDR;
      PC_B, REG_B, MEM_B: if (acc) begin
        word_d = word_q << 8;
        byte_d = byte_q + 2'd1;
        csum_d = csum_q ^ tx_byte;
        if (byte_q == 2'd3) begin
          state_d = (state_q == PC_B) ? REG_FETCH :
                    (state_q == REG_B) ? (last_reg ? MEM_FETCH : REG_FETCH) :
                    (last_mem ? CSUM : MEM_FETCH);
          idx_d   = ((state_q == PC_B) | ((state_q == REG_B) & last_reg)) ? 6'd0 : idx_q + 6'd1;
        end
      end
      REG_FETCH: begin
        word_d  = bus.reg_data;
        state_d = REG_B;
      end
      MEM_FETCH: begin
        word_d  = bus.mem_data;
        state_d = MEM_B;
      end
      CSUM: state_d = acc ? DONE : CSUM;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // addresses are registered on entry to a fetch state so they are stable for its whole cycle
  assign reg_addr_d = (state_d == REG_FETCH) ? idx_d[4:0] : reg_addr_q;
  assign mem_addr_d = (state_d == MEM_FETCH) ? MEM_ADDR_WIDTH'(idx_d) : mem_addr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      halt_q     <= 1'b0;
      word_q     <= '0;
      byte_q     <= '0;
      idx_q      <= '0;
      csum_q     <= '0;
      reg_addr_q <= '0;
      mem_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      halt_q     <= halt_i;
      word_q     <= word_d;
      byte_q     <= byte_d;
      idx_q      <= idx_d;
      csum_q     <= csum_d;
      reg_addr_q <= reg_addr_d;
      mem_addr_q <= mem_addr_d;
    end
  end
endmodule

// File: tb/tb_mips_state_dumper.sv
// tb_mips_state_dumper: directed and randomized frame checks against a byte-list frame model
module tb_mips_state_dumper;
  localparam int MW = 32;

  logic clk = 1'b0, clk_en = 1'b1, rst = 1'b1;
  logic halt = 1'b0, start = 1'b0, bp = 1'b0;
  logic [31:0] pc = '0;
  logic busy, done;
  logic [31:0] rf [32];
  logic [31:0] dm [MW];
  logic [7:0] rx [$];
  logic [7:0] exp_q [$];
  int checks = 0, errors = 0, dones = 0, vcnt = 0;
  logic stall_q = 1'b0;
  logic [7:0] prev_b = '0;

  mips_state_dumper_if #(.DATA_WIDTH(32), .MEM_ADDR_WIDTH(5)) bus ();

  mips_state_dumper #(.DATA_WIDTH(32), .MEM_WORDS(MW), .MEM_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .halt_i(halt), .start_i(start), .pc_i(pc),
    .bus(bus), .busy_o(busy), .done_o(done)
  );

  assign bus.reg_data = rf[bus.reg_addr];
  assign bus.mem_data = dm[bus.mem_addr];

  always #5 clk = clk_en ? ~clk : clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  always @(negedge clk) if (!rst) begin
    if (bus.tx_valid) vcnt++;
    if (bus.tx_valid && bus.tx_ready) rx.push_back(bus.tx_data);
    if (done) dones++;
    if (stall_q) chk("stall_hold", {23'd0, bus.tx_valid, bus.tx_data}, {23'd0, 1'b1, prev_b});
    stall_q = bus.tx_valid && !bus.tx_ready;
    prev_b  = bus.tx_data;
  end

  function automatic void build_exp(input logic [31:0] p);
    logic [31:0] w [$];
    logic [7:0] cs, b;
    w.push_back(p);
    for (int i = 0; i < 32; i++) w.push_back(rf[i]);
    for (int i = 0; i < MW; i++) w.push_back(dm[i]);
    exp_q = {};
    exp_q.push_back(8'hA5);
    cs = 8'h00;
    foreach (w[i]) for (int k = 3; k >= 0; k--) begin
      b = w[i][8*k +: 8];
      exp_q.push_back(b);
      cs ^= b;
    end
    exp_q.push_back(cs);
  endfunction

  task automatic directed_image();
    for (int i = 0; i < 32; i++) rf[i] = i;
    for (int i = 0; i < MW; i++) dm[i] = 32'h1000 + i;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    start = 1'b0;
    bus.tx_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
  endtask

  task automatic run(input string tag, input int start_at, output int n);
    bit sent = 0;
    n = 0;
    while (!done && n < 3000) begin
      tick();
      n++;
      if (n == 1) chk({tag, "/hdr"}, {22'd0, busy, bus.tx_valid, bus.tx_data}, {22'd0, 2'b11, 8'hA5});
      if (start_at >= 0 && !sent && rx.size() >= start_at) begin
        start = 1'b1;
        sent = 1;
      end
    end
    chk({tag, "/no_timeout"}, 32'(n < 3000), 32'd1);
    chk({tag, "/busy_at_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "/len"}, rx.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < rx.size()) chk($sformatf("%s/byte%0d", tag, i), 32'(rx[i]), 32'(exp_q[i]));
  endtask

  initial begin
    int n, d0, v0;
    bus.tx_ready = 1'b1;
    directed_image();
    repeat (3) @(posedge clk);
    #1;
    chk("rst/outs", {busy, done, bus.tx_valid, bus.tx_data}, 11'd0);
    chk("rst/addr", {bus.reg_addr, bus.mem_addr}, 10'd0);
    rst = 1'b0;
    v0 = vcnt;
    repeat (20) tick();
    chk("idle/no_valid", vcnt - v0, 0);

    build_exp(32'h40);
    pc = 32'h40;
    rx = {};
    d0 = dones;
    start = 1'b1;
    run("full", -1, n);
    chk("full/done_cycle", n, 327);
    tick();
    check_frame("full");
    chk("full/csum", 32'(rx[rx.size()-1]), 32'h40);
    chk("full/one_done", dones - d0, 1);

    bp = 1'b1;
    rx = {};
    tick();
    start = 1'b1;
    run("bp", -1, n);
    tick();
    check_frame("bp");
    bp = 1'b0;

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 32; i++) rf[i] = $urandom;
      for (int i = 0; i < MW; i++) dm[i] = $urandom;
      pc = $urandom;
      build_exp(pc);
      bp = 1'(r);
      rx = {};
      tick();
      start = 1'b1;
      run($sformatf("rand%0d", r), -1, n);
      tick();
      check_frame($sformatf("rand%0d", r));
    end
    bp = 1'b0;

    directed_image();
    pc = 32'h40;
    build_exp(pc);
    rx = {};
    d0 = dones;
    tick();
    halt = 1'b1;
    run("filt", 30, n);
    tick();
    check_frame("filt");
    v0 = vcnt;
    repeat (400) tick();
    chk("filt/no_refire", vcnt - v0, 0);
    chk("filt/one_done", dones - d0, 1);
    halt = 1'b0;
    repeat (2) tick();

    rx = {};
    d0 = dones;
    start = 1'b1;
    n = 0;
    while (rx.size() < 50 && n < 1000) begin
      tick();
      n++;
    end
    chk("abort/reached50", 32'(rx.size() >= 50), 32'd1);
    clk_en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("abort/outs", {busy, done, bus.tx_valid, bus.tx_data}, 11'd0);
    #10;
    rst = 1'b0;
    stall_q = 1'b0;
    #3;
    clk_en = 1'b1;
    v0 = vcnt;
    repeat (10) tick();
    chk("abort/no_done", dones - d0, 0);
    chk("abort/quiet", vcnt - v0, 0);
    rx = {};
    start = 1'b1;
    run("restart", -1, n);
    tick();
    check_frame("restart");
    chk("restart/csum", 32'(rx[rx.size()-1]), 32'h40);

    rx = {};
    d0 = dones;
    repeat (2) tick();
    start = 1'b1;
    halt = 1'b1;
    run("both", -1, n);
    chk("both/done_cycle", n, 327);
    repeat (50) tick();
    check_frame("both");
    chk("both/one_done", dones - d0, 1);
    halt = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
